wh_output_allocator: RTL and testbench

- Output-port allocator for one NoC router output port.
- Shares the port between N_REQ input requesters using round-robin arbitration.
- Wormhole locking: the winner keeps the grant from head flit to tail flit.
- Credit-based flow control towards the downstream input buffer; muxes the owner's flit onto the output link.

---
 rtl/noc_alloc_pkg.sv | 22 ++
 rtl/rr_pick.sv | 55 +++++
 rtl/wh_output_allocator.sv | 145 ++++++++++++++
 tb/tb_wh_output_allocator.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_alloc_pkg.sv
// Shared types and helpers for NoC output-port allocation.
//   alloc_state_t : allocator state (IDLE / LOCKED)
//   idx_onehot    : index -> one-hot vector (MAX_REQ bits; callers narrow with a cast)
package noc_alloc_pkg;

    localparam int unsigned MAX_REQ_W = 6;
    localparam int unsigned MAX_REQ   = 1 << MAX_REQ_W;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } alloc_state_t;

    // One-hot encode an index
    function automatic logic [MAX_REQ-1:0] idx_onehot(input logic [MAX_REQ_W-1:0] idx);
        logic [MAX_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick.
//   req_i  : request vector
//   ptr_i  : highest-priority index this round
//   pick_c : one-hot winner (0 when no request)
//   idx_c  : winner index (0 when no request)
//   any_c  : at least one request
// Requests at or above ptr_i are preferred; if none exist the lowest
// request overall wins, which wraps the search around modulo N.
module rr_pick
    import noc_alloc_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  pick_c,
    output logic [IW-1:0] idx_c,
    output logic          any_c
);

    logic [N-1:0]  masked_req;
    logic [IW-1:0] idx_masked;
    logic [IW-1:0] idx_unmasked;
    logic          hit_masked;

    // Keep only requests at or above the pointer
    always_comb begin
        masked_req = '0;
        for (int i = 0; i < int'(N); i++) begin
            masked_req[i] = req_i[i] && (IW'(i) >= ptr_i);
        end
    end

    // Two lowest-index priority encoders; scanning downward leaves the lowest hit
    always_comb begin
        idx_masked   = '0;
        idx_unmasked = '0;
        hit_masked   = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (masked_req[i]) begin
                idx_masked = IW'(i);
                hit_masked = 1'b1;
            end
            if (req_i[i]) begin
                idx_unmasked = IW'(i);
            end
        end
    end

    assign any_c  = |req_i;
    assign idx_c  = hit_masked ? idx_masked : idx_unmasked;
    assign pick_c = any_c ? N'(idx_onehot(MAX_REQ_W'(idx_c))) : '0;

endmodule

// File: rtl/wh_output_allocator.sv
// Wormhole output-port allocator for one NoC router output.
//   clk, arst           : clock, async active-low reset
//   valid_i/head_i/tail_i/flit_i : per-requester flit interface
//   ready_o             : flit taken from requester i this cycle
//   credit_i            : downstream freed one buffer slot
//   flit_o / valid_o    : output link
//   grant_o / locked_o  : current packet owner (registered)
//   credits_o / err_o   : credit count, sticky credit-overflow flag
// A head flit wins the port round-robin; the owner keeps it until its tail
// flit is transferred. Transfers consume a credit and stall at zero credits.
module wh_output_allocator
    import noc_alloc_pkg::*;
#(
    parameter  int unsigned N_REQ   = 4,
    parameter  int unsigned FLIT_W  = 34,
    parameter  int unsigned CREDITS = 4,
    localparam int unsigned CW      = $clog2(CREDITS + 1)
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic [N_REQ-1:0]          valid_i,
    input  logic [N_REQ-1:0]          head_i,
    input  logic [N_REQ-1:0]          tail_i,
    input  logic [N_REQ*FLIT_W-1:0]   flit_i,
    output logic [N_REQ-1:0]          ready_o,
    input  logic                      credit_i,
    output logic [FLIT_W-1:0]         flit_o,
    output logic                      valid_o,
    output logic [N_REQ-1:0]          grant_o,
    output logic                      locked_o,
    output logic [CW-1:0]             credits_o,
    output logic                      err_o
);

    localparam int unsigned IW = $clog2(N_REQ);

    alloc_state_t     state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [CW-1:0]    credits_q, credits_d;
    logic             err_q, err_d;

    logic [N_REQ-1:0]  req;
    logic [N_REQ-1:0]  pick_oh;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic              owner_valid;
    logic              owner_tail;
    logic [FLIT_W-1:0] owner_flit;
    logic              fire;

    // Only head flits compete for the port
    assign req = valid_i & head_i;

    rr_pick #(.N(N_REQ)) u_pick (
        .req_i  (req),
        .ptr_i  (ptr_q),
        .pick_c (pick_oh),
        .idx_c  (pick_idx),
        .any_c  (pick_any)
    );

    // Select the owner's flit signals
    always_comb begin
        owner_valid = 1'b0;
        owner_tail  = 1'b0;
        owner_flit  = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (owner_q == IW'(i)) begin
                owner_valid = valid_i[i];
                owner_tail  = tail_i[i];
                owner_flit  = flit_i[i*FLIT_W +: FLIT_W];
            end
        end
    end

    // A transfer needs the lock, a valid owner flit and a free downstream slot
    assign fire = (state_q == LOCKED) && owner_valid && (credits_q != '0);

    assign ready_o   = fire ? grant_q : '0;
    assign valid_o   = fire;
    assign flit_o    = fire ? owner_flit : '0;
    assign grant_o   = grant_q;
    assign locked_o  = (state_q == LOCKED);
    assign credits_o = credits_q;
    assign err_o     = err_q;

    // Lock / release and round-robin pointer
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = LOCKED;
                    owner_d = pick_idx;
                    grant_d = pick_oh;
                end
            end
            LOCKED: begin
                if (fire && owner_tail) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Credit counter; a return at full count saturates and flags overflow
    always_comb begin
        err_d     = err_q;
        credits_d = credits_q + CW'(credit_i) - CW'(fire);
        if (credit_i && !fire && (credits_q == CW'(CREDITS))) begin
            credits_d = CW'(CREDITS);
            err_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            grant_q   <= '0;
            credits_q <= CW'(CREDITS);
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_wh_output_allocator.sv
// Scoreboard bench for wh_output_allocator: a behavioural model predicts
// transfers and registered status each cycle; a monitor compares the DUT.
module tb_wh_output_allocator;

    localparam int N  = 4;
    localparam int FW = 34;
    localparam int CR = 4;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            arst;
    logic [N-1:0]    valid_i, head_i, tail_i, ready_o, grant_o;
    logic [N*FW-1:0] flit_i;
    logic            credit_i;
    logic [FW-1:0]   flit_o;
    logic            valid_o, locked_o, err_o;
    logic [CW-1:0]   credits_o;

    always #5 clk = ~clk;

    wh_output_allocator #(.N_REQ(N), .FLIT_W(FW), .CREDITS(CR)) dut (
        .clk       (clk),
        .arst      (arst),
        .valid_i   (valid_i),
        .head_i    (head_i),
        .tail_i    (tail_i),
        .flit_i    (flit_i),
        .ready_o   (ready_o),
        .credit_i  (credit_i),
        .flit_o    (flit_o),
        .valid_o   (valid_o),
        .grant_o   (grant_o),
        .locked_o  (locked_o),
        .credits_o (credits_o),
        .err_o     (err_o)
    );

    typedef struct { int cyc; int idx; logic [FW-1:0] flit; } xfer_t;
    typedef struct { logic [N-1:0] grant; logic locked; int credits; logic err; } stat_t;

    xfer_t tr_q[$];
    stat_t st_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    mon_en = 1'b0;

    // Reference model state
    bit m_locked, m_fire, m_err;
    int m_owner, m_ptr, m_cred;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_fire = 0; m_err = 0;
        m_owner = 0; m_ptr = 0; m_cred = CR;
    endtask

    // One cycle of the allocator rules, using the inputs currently driven
    task automatic model_tick();
        stat_t s;
        xfer_t x;
        bit    found;
        s.grant = '0;
        if (m_locked) s.grant[m_owner] = 1'b1;
        s.locked  = m_locked;
        s.credits = m_cred;
        s.err     = m_err;
        st_q.push_back(s);
        m_fire = 0;
        if (!m_locked) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                int c = (m_ptr + k) % N;
                if (!found && valid_i[c] && head_i[c]) begin
                    found = 1; m_owner = c; m_locked = 1;
                end
            end
        end else if (valid_i[m_owner] && m_cred > 0) begin
            m_fire = 1;
            x.cyc = cyc; x.idx = m_owner; x.flit = flit_i[m_owner*FW +: FW];
            tr_q.push_back(x);
            if (tail_i[m_owner]) begin
                m_locked = 0;
                m_ptr = (m_owner + 1) % N;
            end
        end
        if (credit_i && !m_fire && m_cred == CR) m_err = 1;
        else m_cred = m_cred + int'(credit_i) - int'(m_fire);
    endtask

    task automatic tick();
        model_tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] h,
                         input logic [N-1:0] t, input logic cr);
        valid_i = v; head_i = h; tail_i = t; credit_i = cr;
        for (int i = 0; i < N; i++) flit_i[i*FW +: FW] = {2'(i), 32'($urandom)};
        tick();
    endtask

    // Monitor: registered status every cycle, a transfer whenever valid_o is high
    stat_t ms;
    xfer_t mx;
    logic [N-1:0] exp_ready;
    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            if (st_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL status_queue: empty at cycle %0d, required an entry", cyc);
            end else begin
                ms = st_q.pop_front();
                chk("grant_o", 64'(grant_o), 64'(ms.grant));
                chk("locked_o", 64'(locked_o), 64'(ms.locked));
                chk("credits_o", 64'(credits_o), 64'(ms.credits));
                chk("err_o", 64'(err_o), 64'(ms.err));
            end
            if (valid_o) begin
                if (tr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_xfer: valid_o=1 at cycle %0d, required 0", cyc);
                end else begin
                    mx = tr_q.pop_front();
                    exp_ready = '0;
                    exp_ready[mx.idx] = 1'b1;
                    chk("xfer_cycle", 64'(cyc), 64'(mx.cyc));
                    chk("flit_o", 64'(flit_o), 64'(mx.flit));
                    chk("ready_o", 64'(ready_o), 64'(exp_ready));
                end
            end else begin
                chk("ready_idle", 64'(ready_o), 64'(0));
                if (tr_q.size() != 0 && tr_q[0].cyc == cyc) begin
                    mx = tr_q.pop_front();
                    checks++; errors++;
                    $display("FAIL missed_xfer: valid_o=0 at cycle %0d, required 1 from req %0d", cyc, mx.idx);
                end
            end
        end
    end

    int f;
    int act[N], len[N], fidx[N];
    logic [FW-1:0] cur[N];

    initial begin
        arst = 1'b0; valid_i = '0; head_i = '0; tail_i = '0; flit_i = '0; credit_i = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_grant", 64'(grant_o), 64'(0));
        chk("rst_locked", 64'(locked_o), 64'(0));
        chk("rst_credits", 64'(credits_o), 64'(CR));
        chk("rst_err", 64'(err_o), 64'(0));
        chk("rst_valid", 64'(valid_o), 64'(0));
        @(negedge clk);
        arst = 1'b1;
        mon_en = 1'b1;

        // Single 3-flit packet from requester 0; tail coincides with a credit return
        drive(4'b0001, 4'b0001, 4'b0000, 1'b0);
        chk("p1_locked", 64'(locked_o), 64'(1));
        chk("p1_grant", 64'(grant_o), 64'(4'b0001));
        drive(4'b0001, 4'b0001, 4'b0000, 1'b0);
        chk("p1_cred_head", 64'(credits_o), 64'(3));
        drive(4'b0001, 4'b0000, 4'b0000, 1'b0);
        drive(4'b0001, 4'b0000, 4'b0001, 1'b1);
        chk("p1_fire_and_credit", 64'(credits_o), 64'(2));
        chk("p1_released", 64'(locked_o), 64'(0));
        drive(4'b0000, 4'b0000, 4'b0000, 1'b1);
        drive(4'b0000, 4'b0000, 4'b0000, 1'b1);
        chk("p1_cred_back", 64'(credits_o), 64'(4));

        // All four sending single-flit packets; pointer now 1
        for (int k = 0; k < 5; k++) begin
            drive(4'b1111, 4'b1111, 4'b1111, 1'b0);
            chk("rr_grant", 64'(grant_o), 64'(4'b0001 << ((1 + k) % N)));
            drive(4'b1111, 4'b1111, 4'b1111, 1'b1);
            chk("rr_bubble", 64'(locked_o), 64'(0));
        end

        // Credit starvation on requester 2 with a 6-flit packet
        drive(4'b0100, 4'b0100, 4'b0000, 1'b0);
        chk("st_grant", 64'(grant_o), 64'(4'b0100));
        f = 0;
        for (int k = 0; k < 6; k++) begin
            drive(4'b0100, (f == 0) ? 4'b0100 : 4'b0000, (f == 5) ? 4'b0100 : 4'b0000, 1'b0);
            if (m_fire) f++;
        end
        chk("st_credits0", 64'(credits_o), 64'(0));
        chk("st_valid0", 64'(valid_o), 64'(0));
        drive(4'b0100, 4'b0000, 4'b0000, 1'b1);
        chk("st_credit_pulse", 64'(credits_o), 64'(1));
        drive(4'b0100, 4'b0000, 4'b0000, 1'b0);
        if (m_fire) f++;
        chk("st_one_more", 64'(credits_o), 64'(0));
        for (int k = 0; k < 20 && f < 6; k++) begin
            drive(4'b0100, 4'b0000, (f == 5) ? 4'b0100 : 4'b0000, 1'b1);
            if (m_fire) f++;
        end
        for (int k = 0; k < 10 && m_cred < CR; k++) drive(4'b0000, 4'b0000, 4'b0000, 1'b1);

        // Credit return at full count while idle
        drive(4'b0000, 4'b0000, 4'b0000, 1'b1);
        chk("ovf_credits", 64'(credits_o), 64'(CR));
        chk("ovf_err", 64'(err_o), 64'(1));
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0);
        chk("ovf_sticky", 64'(err_o), 64'(1));

        // Reset in the middle of a packet from requester 3; requester 0 waiting
        drive(4'b1000, 4'b1000, 4'b0000, 1'b0);
        chk("mid_grant", 64'(grant_o), 64'(4'b1000));
        for (int k = 0; k < 3; k++)
            drive(4'b1001, (k == 0) ? 4'b1001 : 4'b0001, 4'b0000, 1'b0);
        chk("mid_credits", 64'(credits_o), 64'(1));
        chk("mid_locked", 64'(locked_o), 64'(1));
        mon_en = 1'b0;
        valid_i = 4'b1001; head_i = 4'b1001;
        arst = 1'b0;
        #1;
        chk("arst_grant", 64'(grant_o), 64'(0));
        chk("arst_locked", 64'(locked_o), 64'(0));
        chk("arst_credits", 64'(credits_o), 64'(CR));
        chk("arst_valid", 64'(valid_o), 64'(0));
        chk("arst_err", 64'(err_o), 64'(0));
        model_reset();
        tr_q.delete();
        st_q.delete();
        @(negedge clk);
        arst = 1'b1;
        mon_en = 1'b1;
        drive(4'b1001, 4'b1001, 4'b0000, 1'b0);
        chk("post_rst_grant", 64'(grant_o), 64'(4'b0001));
        drive(4'b1001, 4'b1001, 4'b0001, 1'b0);
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0);

        // Randomised traffic with downstream credit returns
        for (int i = 0; i < N; i++) begin act[i] = 0; len[i] = 0; fidx[i] = 0; cur[i] = '0; end
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (act[i] == 0 && $urandom_range(0, 9) < 3) begin
                    act[i] = 1; len[i] = int'($urandom_range(1, 5)); fidx[i] = 0;
                    cur[i] = {2'(i), 32'($urandom)};
                end
                if (act[i] != 0) begin
                    valid_i[i] = ($urandom_range(0, 3) != 0);
                    head_i[i]  = (fidx[i] == 0);
                    tail_i[i]  = (fidx[i] == len[i] - 1);
                    flit_i[i*FW +: FW] = cur[i];
                end else begin
                    // Stray body flits from non-owners must be ignored
                    valid_i[i] = ($urandom_range(0, 9) == 0);
                    head_i[i]  = 1'b0;
                    tail_i[i]  = 1'($urandom_range(0, 1));
                    flit_i[i*FW +: FW] = {2'(i), 32'($urandom)};
                end
            end
            credit_i = (m_cred < CR) && ($urandom_range(0, 1) == 1);
            model_tick();
            if (m_fire) begin
                fidx[m_owner]++;
                if (fidx[m_owner] == len[m_owner]) act[m_owner] = 0;
                else cur[m_owner] = {2'(m_owner), 32'($urandom)};
            end
            @(negedge clk);
        end

        drive(4'b0000, 4'b0000, 4'b0000, 1'b0);
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0);
        mon_en = 1'b0;
        chk("xfer_queue_drained", 64'(tr_q.size()), 64'(0));
        chk("status_queue_drained", 64'(st_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
